// File: rtl/cam_cmd_scheduler.sv
// Camera command scheduler: queues UART parameter commands and replays each one
// as two SCCB register writes (cam0 then cam1) through the shared write master.
`timescale 1ns/1ps
module cam_cmd_scheduler #(
  parameter int FIFO_AW     = 2,
  parameter int GAP_CYC     = 1000,
  parameter int TIMEOUT_CYC = 500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  command_data,
  input  logic        act_flag,
  input  logic        cam_init_done,
  output logic        cfg_req,
  output logic        cfg_cam_sel,
  output logic [15:0] cfg_reg_addr,
  output logic [7:0]  cfg_reg_data,
  input  logic        cfg_ack,
  input  logic        cfg_done,
  output logic        busy,
  output logic        ovf_err,
  output logic        tmo_err,
  output logic [7:0]  cmd_cnt
);
  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE  = 1;
  localparam logic [19:0]      TMO_LAST = 20'(TIMEOUT_CYC - 1);
  localparam logic [19:0]      GAP_LAST = 20'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_GAP
  } state_t;

  state_t           state_q;
  logic [3:0]       fifo_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [19:0]      timer_q;
  logic             req_q, sel_q, ovf_q, tmo_q;
  logic [15:0]      addr_q;
  logic [7:0]       data_q, cnt_q;

  logic        fifo_empty, fifo_full, pop, push;
  logic [3:0]  head;
  logic [1:0]  lv;
  logic [15:0] dec_addr;
  logic [7:0]  dec_data;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^command_data[7:4];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop  = (state_q == S_LOAD);
  // The LOAD pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign push = act_flag && (!fifo_full || pop);
  assign head = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
  assign lv   = head[1:0];

  always_comb begin
    dec_addr = 16'h3008;
    dec_data = 8'h82;
    case (head[3:2])
      2'b00: begin dec_addr = 16'h5587; dec_data = {2'b00, lv, 4'h0}; end
      2'b01: begin dec_addr = 16'h5586; dec_data = 8'h10 + {3'b000, lv, 3'b000}; end
      2'b10: begin dec_addr = 16'h3821; dec_data = {6'b000000, lv}; end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= command_data[3:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      timer_q  <= '0;
      req_q    <= 1'b0;
      sel_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (act_flag && !push) ovf_q <= 1'b1;
      if (timer_q != '1) timer_q <= timer_q + 20'd1;

      case (state_q)
        S_IDLE: if (!fifo_empty && cam_init_done) state_q <= S_LOAD;
        S_LOAD: begin
          addr_q  <= dec_addr;
          data_q  <= dec_data;
          req_q   <= 1'b1;
          sel_q   <= 1'b0;
          state_q <= S_REQ0;
        end
        // A done arriving together with the ack skips the WAIT state entirely.
        S_REQ0, S_REQ1: if (cfg_ack) begin
          req_q   <= 1'b0;
          timer_q <= '0;
          if (cfg_done && state_q == S_REQ0) begin
            req_q   <= 1'b1;
            sel_q   <= 1'b1;
            state_q <= S_REQ1;
          end else if (cfg_done) begin
            state_q <= S_GAP;
          end else if (state_q == S_REQ0) begin
            state_q <= S_WAIT0;
          end else begin
            state_q <= S_WAIT1;
          end
        end
        S_WAIT0, S_WAIT1: if (cfg_done || timer_q >= TMO_LAST) begin
          if (!cfg_done) tmo_q <= 1'b1;
          if (state_q == S_WAIT0) begin
            req_q   <= 1'b1;
            sel_q   <= 1'b1;
            state_q <= S_REQ1;
          end else begin
            timer_q <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: if (timer_q >= GAP_LAST) begin
          cnt_q   <= cnt_q + 8'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_req      = req_q;
  assign cfg_cam_sel  = sel_q;
  assign cfg_reg_addr = addr_q;
  assign cfg_reg_data = data_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty;
  assign ovf_err      = ovf_q;
  assign tmo_err      = tmo_q;
  assign cmd_cnt      = cnt_q;
endmodule
